// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR port arbiter.
// Also holds the index-width helper used by the arbiter and its picker.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_CNT_W   = 16;

    // Requester index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping from N-1 back to 0. Returns one-hot, index and any-valid.
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the pointer position; first hit wins.
    always_comb begin
        int pos;
        pos    = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int off = 0; off < N; off++) begin
            pos = (int'(ptr) + off) % N;
            if (!any && req[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IW'(pos);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR memory port among NUM_REQ requesters.
// One transaction at a time; the grant is held until the last data beat.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int LEN_W   = DEF_LEN_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arb_v,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic [ADDR_W-1:0]         mem_cmd_addr,
    output logic [LEN_W-1:0]          mem_cmd_len,
    output logic                      mem_cmd_write,
    output logic [ID_W-1:0]           mem_cmd_id,
    input  logic                      beat_valid,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      err_stray,
    output logic [CNT_W-1:0]          txn_count
);

    arb_state_e          state_r, state_s;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     id_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic                write_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    txn_r;
    logic                err_r;

    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                pick_any_s;
    logic                take_s;
    logic                last_beat_s;
    logic [ID_W-1:0]     ptr_next_s;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign take_s      = (state_r == IDLE) && arb_v && pick_any_s;
    assign last_beat_s = (state_r == DATA) && beat_valid && (cnt_r == {LEN_W{1'b0}});
    assign ptr_next_s  = (id_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (id_r + ID_W'(1));

    // Next-state logic for the IDLE -> CMD -> DATA cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_s = CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    state_s = DATA;
                end else begin
                    state_s = CMD;
                end
            end
            DATA: begin
                if (last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Winner command latch and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r    <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            write_r <= 1'b0;
            cnt_r   <= '0;
        end else if (take_s) begin
            id_r    <= pick_idx_s;
            addr_r  <= req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
            len_r   <= req_len[int'(pick_idx_s)*LEN_W +: LEN_W];
            write_r <= req_write[pick_idx_s];
        end else if ((state_r == CMD) && mem_cmd_ready) begin
            cnt_r <= len_r;
        end else if ((state_r == DATA) && beat_valid && !last_beat_s) begin
            cnt_r <= cnt_r - LEN_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fairness pointer, completion counter and sticky stray-beat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            txn_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (last_beat_s) begin
                ptr_r <= ptr_next_s;
                txn_r <= txn_r + CNT_W'(1);
            end else begin
                ptr_r <= ptr_r;
                txn_r <= txn_r;
            end
            if (beat_valid && (state_r != DATA)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // The handshake must be seen in the same IDLE cycle the winner is chosen.
    assign req_ready     = take_s ? pick_onehot_s : {NUM_REQ{1'b0}};
    assign mem_cmd_valid = (state_r == CMD);
    assign mem_cmd_addr  = addr_r;
    assign mem_cmd_len   = len_r;
    assign mem_cmd_write = write_r;
    assign mem_cmd_id    = id_r;
    assign grant         = (state_r != IDLE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_r) : {NUM_REQ{1'b0}};
    assign busy          = (state_r != IDLE);
    assign err_stray     = err_r;
    assign txn_count     = txn_r;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter: round-robin order,
// burst-length boundaries, arb_v gating, stray beats and asynchronous reset.
module tb_ddr_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 16;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      arb_v;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_write;
    logic                      mem_cmd_valid;
    logic                      mem_cmd_ready;
    logic [ADDR_W-1:0]         mem_cmd_addr;
    logic [LEN_W-1:0]          mem_cmd_len;
    logic                      mem_cmd_write;
    logic [ID_W-1:0]           mem_cmd_id;
    logic                      beat_valid;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      err_stray;
    logic [CNT_W-1:0]          txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arb_v         (arb_v),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_write     (req_write),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_cmd_write (mem_cmd_write),
        .mem_cmd_id    (mem_cmd_id),
        .beat_valid    (beat_valid),
        .grant         (grant),
        .busy          (busy),
        .err_stray     (err_stray),
        .txn_count     (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [5];
        order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0; arb_v = 1'b0; req_valid = '0; req_addr = '0;
        req_len = '0; req_write = '0; mem_cmd_ready = 1'b0; beat_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_busy",   64'(busy),          64'd0);
        check_eq("rst_grant",  64'(grant),         64'd0);
        check_eq("rst_cmdv",   64'(mem_cmd_valid), 64'd0);
        check_eq("rst_addr",   64'(mem_cmd_addr),  64'd0);
        check_eq("rst_txn",    64'(txn_count),     64'd0);
        check_eq("rst_err",    64'(err_stray),     64'd0);
        rst_n = 1'b1;

        // 1: single requester, len=3
        tick();
        arb_v = 1'b1; req_valid = 4'b0001; req_addr[31:0] = 32'h1000_0040;
        req_len[7:0] = 8'd3; req_write[0] = 1'b1; mem_cmd_ready = 1'b1;
        #1;
        check_eq("t1_ready",  64'(req_ready),     64'h1);
        check_eq("t1_cmdv0",  64'(mem_cmd_valid), 64'd0);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("t1_cmdv",   64'(mem_cmd_valid), 64'd1);
        check_eq("t1_id",     64'(mem_cmd_id),    64'd0);
        check_eq("t1_addr",   64'(mem_cmd_addr),  64'h1000_0040);
        check_eq("t1_len",    64'(mem_cmd_len),   64'd3);
        check_eq("t1_write",  64'(mem_cmd_write), 64'd1);
        check_eq("t1_grant",  64'(grant),         64'h1);
        check_eq("t1_noready",64'(req_ready),     64'd0);
        tick();
        beat_valid = 1'b1;
        #1;
        check_eq("t1_data_cmdv", 64'(mem_cmd_valid), 64'd0);
        check_eq("t1_data_grant",64'(grant),         64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t1_hold", 64'(grant), 64'h1);
        end
        tick();
        beat_valid = 1'b0;
        #1;
        check_eq("t1_idle",  64'(busy),      64'd0);
        check_eq("t1_txn",   64'(txn_count), 64'd1);

        // 2: all requesting, len=0; pointer is 1 after test 1
        req_len = '0; req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            #1;
            check_eq("t2_ready", 64'(req_ready), 64'(4'b0001 << order[t]));
            tick();
            check_eq("t2_cmd_id",   64'(mem_cmd_id), 64'(order[t]));
            check_eq("t2_cmd_grant",64'(grant),      64'(4'b0001 << order[t]));
            tick();
            beat_valid = 1'b1;
            #1;
            check_eq("t2_data_grant", 64'(grant), 64'(4'b0001 << order[t]));
            tick();
            beat_valid = 1'b0;
            #1;
            check_eq("t2_idle", 64'(busy), 64'd0);
        end
        req_valid = 4'b0000;
        check_eq("t2_txn", 64'(txn_count), 64'd6);

        // 3: arb_v gating; pointer is 2, requester 1 only
        arb_v = 1'b0; req_valid = 4'b0010; req_len[15:8] = 8'd1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check_eq("t3_gated", 64'(req_ready), 64'd0);
            tick();
        end
        check_eq("t3_gated_busy", 64'(busy), 64'd0);
        arb_v = 1'b1;
        #1;
        check_eq("t3_ready", 64'(req_ready), 64'h2);
        tick();
        check_eq("t3_id", 64'(mem_cmd_id), 64'd1);
        arb_v = 1'b0; req_valid = 4'b0000;
        tick();
        beat_valid = 1'b1;
        #1;
        check_eq("t3_data", 64'(busy), 64'd1);
        tick();
        check_eq("t3_data2", 64'(busy), 64'd1);
        tick();
        beat_valid = 1'b0;
        #1;
        check_eq("t3_done", 64'(busy),      64'd0);
        check_eq("t3_txn",  64'(txn_count), 64'd7);

        // 4: len=255 with command backpressure; pointer is 2 -> requester 0
        arb_v = 1'b1; req_valid = 4'b0001; req_addr[31:0] = 32'hABCD_0000;
        req_len[7:0] = 8'd255; req_write[0] = 1'b0; mem_cmd_ready = 1'b0;
        #1;
        check_eq("t4_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t4_wait_v",    64'(mem_cmd_valid), 64'd1);
            check_eq("t4_wait_addr", 64'(mem_cmd_addr),  64'hABCD_0000);
            tick();
        end
        mem_cmd_ready = 1'b1;
        #1;
        check_eq("t4_len",   64'(mem_cmd_len),   64'd255);
        check_eq("t4_write", 64'(mem_cmd_write), 64'd0);
        tick();
        mem_cmd_ready = 1'b0; beat_valid = 1'b1;
        for (int k = 0; k < 255; k++) begin
            #1;
            check_eq("t4_burst", 64'(busy), 64'd1);
            tick();
        end
        #1;
        check_eq("t4_last", 64'(busy), 64'd1);
        tick();
        beat_valid = 1'b0;
        #1;
        check_eq("t4_done", 64'(busy),      64'd0);
        check_eq("t4_txn",  64'(txn_count), 64'd8);

        // 5: stray beat in IDLE
        beat_valid = 1'b1;
        tick();
        beat_valid = 1'b0;
        #1;
        check_eq("t5_err",  64'(err_stray), 64'd1);
        check_eq("t5_txn",  64'(txn_count), 64'd8);
        repeat (3) tick();
        check_eq("t5_sticky", 64'(err_stray), 64'd1);

        // 6: asynchronous reset mid-DATA; pointer is 1 -> requester 2 only
        req_valid = 4'b0100; req_len[23:16] = 8'd5; req_addr[95:64] = 32'h0000_2000;
        #1;
        check_eq("t6_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b0000; mem_cmd_ready = 1'b1;
        tick();
        beat_valid = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy",  64'(busy),          64'd0);
        check_eq("t6_grant", 64'(grant),         64'd0);
        check_eq("t6_cmdv",  64'(mem_cmd_valid), 64'd0);
        check_eq("t6_addr",  64'(mem_cmd_addr),  64'd0);
        check_eq("t6_id",    64'(mem_cmd_id),    64'd0);
        check_eq("t6_txn",   64'(txn_count),     64'd0);
        check_eq("t6_err",   64'(err_stray),     64'd0);
        beat_valid = 1'b0; mem_cmd_ready = 1'b0;
        tick();
        rst_n = 1'b1; req_valid = 4'b1111;
        #1;
        check_eq("t6_first", 64'(req_ready), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
